puf_ecc_key_sequencer: RTL
==========================

// Module: puf_ecc_key_sequencer
// PURPOSE
//  Sequences the Hamming(15,11) ECC decoder during PUF key reconstruction.
//  Accepts NUM_BLOCKS noisy 15-bit codewords over a valid/ready stream and
//  passes each one through the decoder, one at a time.
//  Assembles the corrected 11-bit slices into one key word and counts the
//  blocks that needed correction. Sits between the PUF response/helper-data
//  path and the key consumer.
// PARAMETERS
//  NUM_BLOCKS  8  codewords per key; key width = 11*NUM_BLOCKS (>=1)
//  CNT_W       4  width of corr_cnt; counter saturates at 2**CNT_W-1
// PORTS
//  clk        in   1              single clock, rising edge
//  rst_n      in   1              reset, asynchronous assert, active-low
//  start      in   1              begin reconstruction (honoured in IDLE/DONE)
//  abort      in   1              synchronous abandon; return to IDLE
//  cw_valid   in   1              cw_data valid
//  cw_ready   out  1              sequencer accepts cw_data this cycle
//  cw_data    in   15             codeword; bit i = codeword position i
//  busy       out  1              high in COLLECT/DECODE
//  key_valid  out  1              key_out complete and stable (DONE)
//  key_out    out  11*NUM_BLOCKS  block b in bits [11b+10:11b]
//  corr_cnt   out  CNT_W          number of blocks with non-zero syndrome
// BEHAVIOUR
//  Reset: state=IDLE; cw_ready=0, busy=0, key_valid=0, key_out=0,
//   corr_cnt=0; blk_cnt=0; decoder enable=0.
//  FSM states: IDLE, COLLECT, DECODE, DONE (registered state; all outputs
//   are derived from registers).
//  IDLE: start=1 -> COLLECT. Entry clears blk_cnt, corr_cnt, key_out.
//  COLLECT: cw_ready=1. If cw_valid=1, cw_data -> cw_reg, go to DECODE.
//   Otherwise stay in COLLECT.
//  DECODE: cw_ready=0 and decoder enable=1, driven from cw_reg.
//   At the clock edge, decoded[10:0] is written to key_out slice blk_cnt.
//   Slice bit k = decoder data_out[k].
//   If syndrome(cw_reg)!=0, corr_cnt increments, saturating.
//   If blk_cnt==NUM_BLOCKS-1 -> DONE. Otherwise blk_cnt++ -> COLLECT.
//  DONE: key_valid=1; key_out and corr_cnt stay frozen.
//   start=1 -> COLLECT with a cleared key (key_valid drops next cycle).
//  Throughput: at most 1 codeword every 2 cycles.
//   Latency: key_valid rises 2 cycles after the final accept edge.
//  Decoder enable is 0 outside DECODE, so the decoder output is 0 there.
//  start while busy: ignored.
//  abort=1 in any state -> IDLE next cycle. Clears key_out, corr_cnt,
//   key_valid. abort has priority over start and over a handshake in the
//   same cycle.
//  Syndrome = 3-bit... not used; the syndrome is 4 bits, with s[j] = XOR of
//   positions p where bit j of (p+1) is set. Any non-zero syndrome counts as
//   a correction, including multi-bit errors that are silently miscorrected.
//  rst_n low mid-operation: every register returns to its reset value
//   immediately. No partial key remains visible.
// STRUCTURE
//  Shared package puf_ecc_pkg:
//   localparams CW_W=15, DATA_W=11, SYN_W=4.
//   function hamming_syndrome(cw) -> 4 bits.
//   FSM state encoding.
//  Sub-module: one instance of the existing decoder
//   (c_h <- cw_reg, enable <- state==DECODE, data_out -> decoded).
//   The sequencer does no correction of its own.
// TESTING
//  1 start; 8 blocks of 15'h0000 with cw_valid held high -> cw_ready pulses
//    every 2nd cycle; key_valid 2 cycles after the 8th accept; key_out=0,
//    corr_cnt=0.
//  2 block0=15'h0007 (valid codeword), rest 0 -> key_out[10:0]=11'h001,
//    corr_cnt=0.
//  3 block0=15'h0003 (position 2 flipped), block5=15'h0020 -> key_out[10:0]
//    =11'h001, slice5=0, corr_cnt=2.
//  4 Inject an error in all 8 blocks with CNT_W=2 -> corr_cnt saturates
//    at 3.
//  5 abort asserted in the same cycle as the 4th handshake -> IDLE; word
//    not consumed; key_out=0; a following start yields a correct full key.
//  6 Drop rst_n during DECODE of block 3 -> all outputs 0 at once; with
//    cw_valid gaps, start after release -> correct key.

Source files
------------

// File: rtl/puf_ecc_pkg.sv
// Shared Hamming(15,11) definitions for the PUF key reconstruction path.
// Latency: not applicable (constants, types and pure functions only).
// Backpressure: not applicable.
package puf_ecc_pkg;

    localparam int CW_W   = 15;
    localparam int DATA_W = 11;
    localparam int SYN_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DECODE  = 2'd2,
        ST_DONE    = 2'd3
    } seq_state_t;

    // s[j] is the parity of every codeword position p whose index p+1 has bit j set,
    // so a single flipped position p yields syndrome p+1.
    function automatic logic [SYN_W-1:0] hamming_syndrome(input logic [CW_W-1:0] cw);
        logic [SYN_W-1:0] s;
        s = '0;
        for (int p = 0; p < CW_W; p++) begin
            for (int j = 0; j < SYN_W; j++) begin
                if ((((p + 1) >> j) & 1) != 0) begin
                    s[j] = s[j] ^ cw[p];
                end
            end
        end
        return s;
    endfunction

    // Data bits sit at the positions whose index p+1 is not a power of two,
    // taken in ascending order: 2, 4..6, 8..14.
    function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
        return {cw[14:8], cw[6:4], cw[2]};
    endfunction

endpackage

// File: rtl/puf_ecc_key_sequencer_dec.sv
// Hamming(15,11) single-error-correcting decoder, output gated by enable.
// Latency: combinational.
// Backpressure: none; the caller holds c_h stable while enable is high.
module puf_ecc_key_sequencer_dec
    import puf_ecc_pkg::*;
(
    input  logic              enable,
    input  logic [CW_W-1:0]   c_h,
    output logic [DATA_W-1:0] data_out
);

    logic [SYN_W-1:0] syn;
    logic [CW_W-1:0]  fixed_cw;

    // Flip the position named by the syndrome, then strip the parity positions.
    always_comb begin
        syn      = hamming_syndrome(c_h);
        fixed_cw = c_h;
        if (syn != '0) begin
            fixed_cw[syn - SYN_W'(1)] = ~fixed_cw[syn - SYN_W'(1)];
        end
        data_out = enable ? extract_data(fixed_cw) : '0;
    end

endmodule

// File: rtl/puf_ecc_key_sequencer.sv
// Collects NUM_BLOCKS noisy codewords, decodes each into an 11-bit key slice, counts corrections.
// Latency: one codeword per 2 cycles; key_valid rises 2 cycles after the cycle the final word is accepted.
// Backpressure: cw_ready is high only in COLLECT; the word is taken on cw_valid & cw_ready unless abort is high.
module puf_ecc_key_sequencer
    import puf_ecc_pkg::*;
#(
    parameter int NUM_BLOCKS = 8,
    parameter int CNT_W      = 4
)(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         cw_valid,
    output logic                         cw_ready,
    input  logic [CW_W-1:0]              cw_data,
    output logic                         busy,
    output logic                         key_valid,
    output logic [DATA_W*NUM_BLOCKS-1:0] key_out,
    output logic [CNT_W-1:0]             corr_cnt
);

    localparam int                KEY_W    = DATA_W * NUM_BLOCKS;
    localparam int                BLK_W    = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam logic [BLK_W-1:0]  LAST_BLK = BLK_W'(NUM_BLOCKS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    seq_state_t        state_q,   state_d;
    logic [BLK_W-1:0]  blk_cnt_q, blk_cnt_d;
    logic [CW_W-1:0]   cw_reg_q,  cw_reg_d;
    logic [KEY_W-1:0]  key_q,     key_d;
    logic [CNT_W-1:0]  corr_q,    corr_d;

    logic              accept;
    logic              clear;
    logic              dec_en;
    logic [DATA_W-1:0] decoded;

    assign dec_en = (state_q == ST_DECODE);

    puf_ecc_key_sequencer_dec u_dec (
        .enable   (dec_en),
        .c_h      (cw_reg_q),
        .data_out (decoded)
    );

    // Next-state logic; abort wins over start and over a pending handshake.
    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        accept  = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            clear   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d = ST_COLLECT;
                        clear   = 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (cw_valid) begin
                        state_d = ST_DECODE;
                        accept  = 1'b1;
                    end
                end
                ST_DECODE: begin
                    state_d = (blk_cnt_q == LAST_BLK) ? ST_DONE : ST_COLLECT;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath: capture the codeword, then write its decoded slice and bump the counters.
    always_comb begin
        blk_cnt_d = blk_cnt_q;
        cw_reg_d  = cw_reg_q;
        key_d     = key_q;
        corr_d    = corr_q;
        if (clear) begin
            blk_cnt_d = '0;
            key_d     = '0;
            corr_d    = '0;
        end else if (accept) begin
            cw_reg_d = cw_data;
        end else if (state_q == ST_DECODE) begin
            key_d[int'(blk_cnt_q)*DATA_W +: DATA_W] = decoded;
            // Any non-zero syndrome counts, even a multi-bit error the decoder gets wrong.
            if ((hamming_syndrome(cw_reg_q) != '0) && (corr_q != CNT_MAX)) begin
                corr_d = corr_q + 1'b1;
            end
            if (blk_cnt_q != LAST_BLK) begin
                blk_cnt_d = blk_cnt_q + 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; reset wipes any partially assembled key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt_q <= '0;
            cw_reg_q  <= '0;
            key_q     <= '0;
            corr_q    <= '0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
            cw_reg_q  <= cw_reg_d;
            key_q     <= key_d;
            corr_q    <= corr_d;
        end
    end

    assign cw_ready  = (state_q == ST_COLLECT);
    assign busy      = (state_q == ST_COLLECT) || (state_q == ST_DECODE);
    assign key_valid = (state_q == ST_DONE);
    assign key_out   = key_q;
    assign corr_cnt  = corr_q;

endmodule
